axi4_mem_responder: RTL and testbench

- Synthesizable AXI4 slave memory model that answers the reduced AXI4 master subset used by our RTL kernels: AW/W/B/AR/R channels with len, no id, size, burst or resp signals.
- It sits on the kernel's m_axi port in unit benches and in standalone hardware loopback builds, standing in for device DDR.
- Write and read channels run independently and concurrently against one shared word-addressed array.

---
 rtl/axi4_mem_responder_if.sv | 38 +++
 rtl/axi4_mem_responder.sv | 156 +++++++++++++++
 tb/tb_axi4_mem_responder.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/axi4_mem_responder_if.sv
// Reduced AXI4 bus (AW/W/B/AR/R with len only) between a kernel master and
// the axi4_mem_responder memory model.
interface axi4_mem_responder_if #(
  parameter int unsigned C_ADDR_WIDTH = 64,
  parameter int unsigned C_DATA_WIDTH = 32
);
  logic                      awvalid;
  logic                      awready;
  logic [C_ADDR_WIDTH-1:0]   awaddr;
  logic [7:0]                awlen;
  logic                      wvalid;
  logic                      wready;
  logic [C_DATA_WIDTH-1:0]   wdata;
  logic [C_DATA_WIDTH/8-1:0] wstrb;
  logic                      wlast;
  logic                      bvalid;
  logic                      bready;
  logic                      arvalid;
  logic                      arready;
  logic [C_ADDR_WIDTH-1:0]   araddr;
  logic [7:0]                arlen;
  logic                      rvalid;
  logic                      rready;
  logic [C_DATA_WIDTH-1:0]   rdata;
  logic                      rlast;

  modport master (
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    input  awready, wready, bvalid, arready, rvalid, rdata, rlast
  );

  modport slave (
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
           arvalid, araddr, arlen, rready,
    output awready, wready, bvalid, arready, rvalid, rdata, rlast
  );
endinterface

// File: rtl/axi4_mem_responder.sv
// AXI4 slave memory model: independent write/read FSMs over one word array.
// Define AXI_MEM_STALL_EN to throttle wready/rvalid from a 16-bit LFSR.
module axi4_mem_responder #(
  parameter int unsigned C_ADDR_WIDTH = 64,
  parameter int unsigned C_DATA_WIDTH = 32,
  parameter int unsigned C_MEM_DEPTH  = 4096
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  axi4_mem_responder_if.slave       s_axi,
  output logic                      protocol_err,
  output logic [31:0]               wr_burst_cnt,
  output logic [31:0]               rd_burst_cnt
);
  localparam int unsigned C_BYTES = C_DATA_WIDTH / 8;
  localparam int unsigned C_OFF   = $clog2(C_BYTES);
  localparam int unsigned C_IDX   = $clog2(C_MEM_DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         rd_state_t;

  wr_state_t              r_wr_state, w_wr_next;
  rd_state_t              r_rd_state, w_rd_next;
  logic [C_IDX-1:0]       r_wr_ptr, r_rd_ptr;
  logic [7:0]             r_wr_beats, r_rd_beats;
  logic                   r_err;
  logic [31:0]            r_wr_cnt, r_rd_cnt;
  logic [C_DATA_WIDTH-1:0] r_mem [C_MEM_DEPTH];
  logic                   w_wr_gate, w_rd_gate;
  logic                   w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

`ifdef AXI_MEM_STALL_EN
  logic [15:0] r_lfsr;
  logic        r_rvalid_d;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_lfsr     <= 16'hACE1;
      r_rvalid_d <= 1'b0;
    end else begin
      r_lfsr     <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
      r_rvalid_d <= s_axi.rvalid;
    end
  end

  // rvalid may only be withheld when it was low last cycle, so it never drops before a handshake
  assign w_wr_gate = (r_lfsr[1:0] != 2'b00);
  assign w_rd_gate = r_rvalid_d || (r_lfsr[3:2] != 2'b00);
`else
  assign w_wr_gate = 1'b1;
  assign w_rd_gate = 1'b1;
`endif

  assign w_aw_hs = s_axi.awvalid & s_axi.awready;
  assign w_w_hs  = s_axi.wvalid  & s_axi.wready;
  assign w_b_hs  = s_axi.bvalid  & s_axi.bready;
  assign w_ar_hs = s_axi.arvalid & s_axi.arready;
  assign w_r_hs  = s_axi.rvalid  & s_axi.rready;

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_wr_state <= W_IDLE;
      r_rd_state <= R_IDLE;
    end else begin
      r_wr_state <= w_wr_next;
      r_rd_state <= w_rd_next;
    end
  end

  always_comb begin
    w_wr_next     = r_wr_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (r_wr_state)
      W_IDLE: begin
        s_axi.awready = 1'b1;
        if (s_axi.awvalid) w_wr_next = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = w_wr_gate;
        if (s_axi.wvalid && w_wr_gate && (r_wr_beats == 8'd0)) w_wr_next = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_wr_next = W_IDLE;
      end
      default: w_wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    w_rd_next     = r_rd_state;
    s_axi.arready = 1'b0;
    s_axi.rvalid  = 1'b0;
    s_axi.rlast   = 1'b0;
    case (r_rd_state)
      R_IDLE: begin
        s_axi.arready = 1'b1;
        if (s_axi.arvalid) w_rd_next = R_DATA;
      end
      R_DATA: begin
        s_axi.rvalid = w_rd_gate;
        s_axi.rlast  = (r_rd_beats == 8'd0);
        if (w_rd_gate && s_axi.rready && (r_rd_beats == 8'd0)) w_rd_next = R_IDLE;
      end
      default: w_rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (areset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_wr_beats <= '0;
      r_rd_beats <= '0;
      r_err      <= 1'b0;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
    end else begin
      if (w_aw_hs) begin
        r_wr_ptr   <= C_IDX'(s_axi.awaddr >> C_OFF);
        r_wr_beats <= s_axi.awlen;
      end else if (w_w_hs) begin
        r_wr_ptr   <= r_wr_ptr + 1'b1;
        r_wr_beats <= r_wr_beats - 8'd1;
        // beat count alone ends the burst; wlast is only cross-checked
        if (s_axi.wlast != (r_wr_beats == 8'd0)) r_err <= 1'b1;
      end
      if (w_b_hs) r_wr_cnt <= r_wr_cnt + 32'd1;

      if (w_ar_hs) begin
        r_rd_ptr   <= C_IDX'(s_axi.araddr >> C_OFF);
        r_rd_beats <= s_axi.arlen;
      end else if (w_r_hs) begin
        r_rd_ptr   <= r_rd_ptr + 1'b1;
        r_rd_beats <= r_rd_beats - 8'd1;
        if (r_rd_beats == 8'd0) r_rd_cnt <= r_rd_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (w_w_hs) begin
      for (int unsigned i = 0; i < C_BYTES; i++) begin
        if (s_axi.wstrb[i]) r_mem[r_wr_ptr][i*8 +: 8] <= s_axi.wdata[i*8 +: 8];
      end
    end
  end

  // asynchronous read gives read-first behaviour against a same-cycle write
  assign s_axi.rdata  = r_mem[r_rd_ptr];
  assign protocol_err = r_err;
  assign wr_burst_cnt = r_wr_cnt;
  assign rd_burst_cnt = r_rd_cnt;
endmodule

// File: tb/tb_axi4_mem_responder.sv
// Directed bench for axi4_mem_responder: reference memory model feeds a
// scoreboard of expected read beats compared as R handshakes occur.
module tb_axi4_mem_responder;
  logic        clk = 1'b0;
  logic        areset;
  logic        protocol_err;
  logic [31:0] wr_burst_cnt, rd_burst_cnt;

  int n_pass  = 0;
  int n_total = 0;
  int exp_wr  = 0;
  int exp_rd  = 0;

  logic [31:0] ref_mem [4096];
  logic [31:0] sb [$];

  always #5 clk = ~clk;

  axi4_mem_responder_if #(.C_ADDR_WIDTH(64), .C_DATA_WIDTH(32)) bus ();

  axi4_mem_responder #(
    .C_ADDR_WIDTH(64),
    .C_DATA_WIDTH(32),
    .C_MEM_DEPTH (4096)
  ) dut (
    .ap_clk       (clk),
    .areset       (areset),
    .s_axi        (bus.slave),
    .protocol_err (protocol_err),
    .wr_burst_cnt (wr_burst_cnt),
    .rd_burst_cnt (rd_burst_cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wait_high(input int sel, input string tag);
    logic v;
    for (int t = 0; t < 200; t++) begin
      case (sel)
        0: v = bus.awready;
        1: v = bus.wready;
        2: v = bus.bvalid;
        3: v = bus.arready;
        default: v = bus.rvalid;
      endcase
      if (v === 1'b1) return;
      @(negedge clk);
    end
    n_total++;
    $error("FAIL timeout_%s: observed 0 expected 1 within 200 cycles", tag);
  endtask

  task automatic wr_burst(input logic [63:0] addr, input int len, input logic [31:0] base,
                          input logic [3:0] strb, input int bad_beat);
    int idx0, idx;
    idx0 = int'(addr[13:2]);
    bus.awvalid = 1'b1;
    bus.awaddr  = addr;
    bus.awlen   = 8'(len);
    wait_high(0, "awready");
    @(negedge clk);
    bus.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = base + 32'(i);
      bus.wstrb  = strb;
      bus.wlast  = (i == len) ^ (i == bad_beat);
      wait_high(1, "wready");
      idx = (idx0 + i) % 4096;
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[idx][b*8 +: 8] = bus.wdata[b*8 +: 8];
      @(negedge clk);
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      check("bvalid_after_beat", bus.bvalid, (i == len));
      if (i == bad_beat) check("perr_set", protocol_err, 1);
    end
    bus.bready = 1'b1;
    wait_high(2, "bvalid");
    @(negedge clk);
    bus.bready = 1'b0;
    exp_wr++;
    check("wr_cnt", wr_burst_cnt, exp_wr);
    check("awready_after_b", bus.awready, 1);
  endtask

  task automatic rd_burst(input logic [63:0] addr, input int len, input logic [15:0] stall_mask,
                          input int abort_beat);
    int idx0;
    logic [31:0] hold_d, exp_d;
    logic        hold_l;
    idx0 = int'(addr[13:2]);
    for (int i = 0; i <= len; i++) sb.push_back(ref_mem[(idx0 + i) % 4096]);
    bus.arvalid = 1'b1;
    bus.araddr  = addr;
    bus.arlen   = 8'(len);
    wait_high(3, "arready");
    @(negedge clk);
    bus.arvalid = 1'b0;
    check("r_first_latency", bus.rvalid, 1);
    for (int i = 0; i <= len; i++) begin
      wait_high(4, "rvalid");
      if (i == abort_beat) begin
        areset = 1'b1;
        @(negedge clk);
        areset = 1'b0;
        check("rst_rvalid", bus.rvalid, 0);
        check("rst_arready", bus.arready, 1);
        check("rst_rd_cnt", rd_burst_cnt, 0);
        check("rst_perr", protocol_err, 0);
        sb.delete();
        exp_rd = 0;
        exp_wr = 0;
        return;
      end
      if (stall_mask[i]) begin
        bus.rready = 1'b0;
        hold_d = bus.rdata;
        hold_l = bus.rlast;
        @(negedge clk);
        check("stall_rvalid", bus.rvalid, 1);
        check("stall_rdata", bus.rdata, hold_d);
        check("stall_rlast", bus.rlast, hold_l);
      end
      bus.rready = 1'b1;
      if (sb.size() == 0) begin
        n_total++;
        $error("FAIL sb_empty: observed empty scoreboard expected beat %0d", i);
        exp_d = 'x;
      end else exp_d = sb.pop_front();
      check("rdata", bus.rdata, exp_d);
      check("rlast", bus.rlast, (i == len));
      @(negedge clk);
      bus.rready = 1'b0;
    end
    exp_rd++;
    check("rd_cnt", rd_burst_cnt, exp_rd);
    check("arready_after_r", bus.arready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed no finish expected finish by 500us");
    $fatal(1);
  end

  initial begin
    areset      = 1'b1;
    bus.awvalid = 1'b0; bus.awaddr = '0; bus.awlen = '0;
    bus.wvalid  = 1'b0; bus.wdata  = '0; bus.wstrb = '0; bus.wlast = 1'b0;
    bus.bready  = 1'b0;
    bus.arvalid = 1'b0; bus.araddr = '0; bus.arlen = '0;
    bus.rready  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", bus.awready, 1);
    check("rst_arready0", bus.arready, 1);
    check("rst_wready", bus.wready, 0);
    check("rst_bvalid", bus.bvalid, 0);
    check("rst_rvalid0", bus.rvalid, 0);
    check("rst_rlast", bus.rlast, 0);
    check("rst_perr0", protocol_err, 0);
    check("rst_wr_cnt", wr_burst_cnt, 0);
    check("rst_rd_cnt0", rd_burst_cnt, 0);
    areset = 1'b0;
    @(negedge clk);

    // single write to word 16 and single-beat readback
    wr_burst(64'h40, 0, 32'hDEADBEEF, 4'hF, -1);
    check("word16_model", ref_mem[16], 32'hDEADBEEF);
    rd_burst(64'h40, 0, 16'h0, -1);

    // partial strobe merge into word 0
    wr_burst(64'h0, 0, 32'h11223344, 4'hF, -1);
    wr_burst(64'h0, 0, 32'hAABBCCDD, 4'b0101, -1);
    check("word0_model", ref_mem[0], 32'h11BB33DD);
    rd_burst(64'h0, 0, 16'h0, -1);

    // 16-beat burst with two read stalls
    wr_burst(64'h100, 15, 32'h0, 4'hF, -1);
    rd_burst(64'h100, 15, 16'h0088, -1);

    // wrap from word 4095 to 0
    wr_burst(64'h3FFC, 3, 32'h500, 4'hF, -1);
    rd_burst(64'h3FFC, 3, 16'h0, -1);
    rd_burst(64'h0, 0, 16'h0, -1);

    // early wlast on beat 1: flag sets, burst still runs 4 beats
    check("perr_before", protocol_err, 0);
    wr_burst(64'h200, 3, 32'h700, 4'hF, 1);
    check("perr_sticky", protocol_err, 1);
    rd_burst(64'h200, 3, 16'h0, -1);
    check("perr_still", protocol_err, 1);

    // reset during beat 5 of a read, memory preserved
    rd_burst(64'h100, 15, 16'h0, 5);
    check("rst_wr_cnt_mid", wr_burst_cnt, 0);
    rd_burst(64'h100, 15, 16'h0, -1);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
